clk_enable_gen: RTL and testbench

//  Multi-channel clock-enable / divided-clock generator fed by a PLL output (e.g. 199.8 MHz).

---
 rtl/clk_enable_gen.sv | 170 +++++++++++++++++
 tb/tb_clk_enable_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable / divided-clock generator with lock-qualified reset sequencing.
// Optional build macro: CLK_ENABLE_GEN_PHASE_ALIGN_EN (in RUN, a ratio load realigns all channels).
module clk_enable_gen #(
  parameter int CHANNELS    = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 6,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic                          in_pll_lock,
  input  logic [CHANNELS*DIV_WIDTH-1:0] in_div,
  input  logic                          in_div_load,
  output logic [CHANNELS-1:0]           out_ce,
  output logic [CHANNELS-1:0]           out_clk_div,
  output logic                          out_rst_sync,
  output logic                          out_ready
);

  localparam int STAB_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t              state_reg;
  logic                lock_meta_reg;
  logic                lock_s_reg;
  logic [STAB_W-1:0]   stab_reg;
  logic                rst_sync_reg;
  logic                ready_reg;
  logic                running;
  logic                realign;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= in_pll_lock;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_reg    <= WAIT_LOCK;
      stab_reg     <= '0;
      rst_sync_reg <= 1'b1;
      ready_reg    <= 1'b0;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          if (lock_s_reg) begin
            state_reg <= STABILIZE;
            stab_reg  <= '0;
          end
        end
        STABILIZE: begin
          if (!lock_s_reg) begin
            state_reg <= WAIT_LOCK;
            stab_reg  <= '0;
          end else if (stab_reg == STAB_W'(LOCK_CYCLES - 1)) begin
            state_reg    <= RUN;
            rst_sync_reg <= 1'b0;
            ready_reg    <= 1'b1;
          end else begin
            stab_reg <= stab_reg + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s_reg) begin
            state_reg    <= WAIT_LOCK;
            stab_reg     <= '0;
            rst_sync_reg <= 1'b1;
            ready_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg    <= WAIT_LOCK;
          stab_reg     <= '0;
          rst_sync_reg <= 1'b1;
          ready_reg    <= 1'b0;
        end
      endcase
    end
  end

  // Channels only advance while RUN is still backed by a valid lock; loss clears them on the same edge.
  assign running = (state_reg == RUN) && lock_s_reg;

`ifdef CLK_ENABLE_GEN_PHASE_ALIGN_EN
  assign realign = running && in_div_load;
`else
  assign realign = 1'b0;
`endif

  assign out_rst_sync = rst_sync_reg;
  assign out_ready    = ready_reg;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DIV_WIDTH-1:0] shadow_reg;
      logic [DIV_WIDTH-1:0] active_reg;
      logic [DIV_WIDTH-1:0] cnt_reg;
      logic                 ce_reg;
      logic                 clk_div_reg;
      logic [DIV_WIDTH-1:0] div_in;
      logic [DIV_WIDTH-1:0] shadow_next;
      logic [DIV_WIDTH-1:0] eff_div;
      logic [DIV_WIDTH:0]   half;
      logic [DIV_WIDTH-1:0] restart_cnt;
      logic                 wrap;

      assign div_in      = in_div[gi*DIV_WIDTH +: DIV_WIDTH];
      assign shadow_next = in_div_load ? div_in : shadow_reg;
      assign eff_div     = (active_reg == '0) ? DIV_WIDTH'(1) : active_reg;
      assign wrap        = (cnt_reg == eff_div - DIV_WIDTH'(1));
      assign half        = ({1'b0, eff_div} + (DIV_WIDTH+1)'(1)) >> 1;

`ifdef CLK_ENABLE_GEN_PHASE_ALIGN_EN
      // The load cycle itself counts as phase 0, so the first enable lands div cycles after it.
      assign restart_cnt = (div_in > DIV_WIDTH'(1)) ? DIV_WIDTH'(1) : '0;
`else
      assign restart_cnt = '0;
`endif

      always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
          shadow_reg  <= DIV_WIDTH'(DEFAULT_DIV);
          active_reg  <= DIV_WIDTH'(DEFAULT_DIV);
          cnt_reg     <= '0;
          ce_reg      <= 1'b0;
          clk_div_reg <= 1'b0;
        end else begin
          shadow_reg <= shadow_next;
          if (!running) begin
            cnt_reg     <= '0;
            ce_reg      <= 1'b0;
            clk_div_reg <= 1'b0;
            // Outside RUN a load takes effect directly so it governs the first RUN period.
            if ((state_reg != RUN) && in_div_load) begin
              active_reg <= div_in;
            end
          end else if (realign) begin
            active_reg  <= div_in;
            cnt_reg     <= restart_cnt;
            ce_reg      <= 1'b0;
            clk_div_reg <= 1'b1;
          end else begin
            ce_reg      <= wrap;
            clk_div_reg <= ({1'b0, cnt_reg} < half);
            if (wrap) begin
              cnt_reg    <= '0;
              active_reg <= shadow_next;
            end else begin
              cnt_reg <= cnt_reg + DIV_WIDTH'(1);
            end
          end
        end
      end

      assign out_ce[gi]      = ce_reg;
      assign out_clk_div[gi] = clk_div_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: table-driven ratio vectors plus lock/reset/load sequences.
module tb_clk_enable_gen;
  localparam int CH = 2;
  localparam int W  = 8;
  localparam int LC = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            lock;
  logic [CH*W-1:0] div;
  logic            load;
  logic [CH-1:0]   ce;
  logic [CH-1:0]   cdiv;
  logic            rsync;
  logic            ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int d0;
    int d1;
    int ncyc;
  } vec_t;

  typedef struct {
    logic [1:0] ce;
    logic [1:0] cdiv;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[4];

  clk_enable_gen #(
    .CHANNELS(CH), .DIV_WIDTH(W), .DEFAULT_DIV(6), .LOCK_CYCLES(LC)
  ) dut (
    .in_clk(clk), .in_rst(rst), .in_pll_lock(lock), .in_div(div), .in_div_load(load),
    .out_ce(ce), .out_clk_div(cdiv), .out_rst_sync(rsync), .out_ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic bit ce_at(int k, int d);
    int e = (d == 0) ? 1 : d;
    return (k >= 1) && (k % e == 0);
  endfunction

  function automatic bit cd_at(int k, int d);
    int e = (d == 0) ? 1 : d;
    return (k >= 1) && (((k - 1) % e) < (e + 1) / 2);
  endfunction

  // Reset with lock held high, optionally load ratios in the first cycle, wait for RUN.
  // Returns at the sampling point of T0 (first RUN cycle).
  task automatic bring_up(input int d0, input int d1, input bit do_load, input string tag);
    int edges;
    rst  = 1'b1;
    lock = 1'b1;
    load = 1'b0;
    div  = {W'(d1), W'(d0)};
    repeat (2) @(negedge clk);
    check({tag, "_rst_ready"}, 32'(ready), 0);
    check({tag, "_rst_rsync"}, 32'(rsync), 1);
    check({tag, "_rst_ce"}, 32'(ce), 0);
    check({tag, "_rst_cdiv"}, 32'(cdiv), 0);
    rst   = 1'b0;
    load  = do_load;
    edges = 0;
    while (!ready && edges < 100) begin
      @(negedge clk);
      edges++;
      load = 1'b0;
    end
    check({tag, "_lock_to_ready"}, 32'(edges), 32'(2 + 1 + LC));
    check({tag, "_rsync_fall"}, 32'(rsync), 0);
  endtask

  task automatic run_check(input int d0, input int d1, input int n, input string tag);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      sb.push_back('{ce: {ce_at(k, d1), ce_at(k, d0)}, cdiv: {cd_at(k, d1), cd_at(k, d0)}});
    end
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s_ce_k%0d", tag, k), 32'(ce), 32'(e.ce));
      check($sformatf("%s_cdiv_k%0d", tag, k), 32'(cdiv), 32'(e.cdiv));
    end
  endtask

  // Mid-run ratio change on ch0 (ch1 ratio re-written unchanged) in cycle load_k after T0.
  task automatic run_load(input int d0, input int d1, input int nd0, input int load_k,
                          input int n, input string tag);
    exp_t e;
    int   wpt;
    bit   e0, e1;
    wpt = ((load_k / d0) + 1) * d0;
    for (int k = 0; k < n; k++) begin
`ifdef CLK_ENABLE_GEN_PHASE_ALIGN_EN
      e0 = (k <= load_k) ? ce_at(k, d0) : ((k - load_k) % nd0 == 0);
      e1 = (k <= load_k) ? ce_at(k, d1) : ((k - load_k) % d1 == 0);
`else
      e0 = (k <= wpt) ? ce_at(k, d0) : ((k - wpt) % nd0 == 0);
      e1 = ce_at(k, d1);
`endif
      sb.push_back('{ce: {e1, e0}, cdiv: 2'b00});
    end
    bring_up(d0, d1, 1'b1, tag);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s_ce_k%0d", tag, k), 32'(ce), 32'(e.ce));
      if (k == load_k) begin
        div  = {W'(d1), W'(nd0)};
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
    $display("seq %s: div0 %0d->%0d at k=%0d, ch0 wrap point %0d, checks=%0d", tag, d0, nd0,
             load_k, wpt, checks);
  endtask

  initial begin
    int edges;
    rst  = 1'b1;
    lock = 1'b0;
    load = 1'b0;
    div  = '0;

    vecs[0] = '{d0: 6, d1: 3, ncyc: 24};
    vecs[1] = '{d0: 0, d1: 5, ncyc: 12};
    vecs[2] = '{d0: 1, d1: 4, ncyc: 12};
    vecs[3] = '{d0: 7, d1: 2, ncyc: 21};

    for (int v = 0; v < 4; v++) begin
      bring_up(vecs[v].d0, vecs[v].d1, 1'b1, $sformatf("vec%0d", v));
      run_check(vecs[v].d0, vecs[v].d1, vecs[v].ncyc, $sformatf("vec%0d", v));
      $display("vec %0d div0=%0d div1=%0d cycles=%0d checks=%0d", v, vecs[v].d0, vecs[v].d1,
               vecs[v].ncyc, checks);
    end

    run_load(6, 5, 4, 3, 20, "load_mid");
    run_load(6, 5, 4, 5, 20, "load_wrap");

    // Single-cycle lock drop while ch0 enables every cycle.
    bring_up(1, 2, 1'b1, "lockdrop");
    repeat (3) @(negedge clk);
    check("lockdrop_ce_before", 32'(ce[0]), 1);
    lock  = 1'b0;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
      if (edges == 1) lock = 1'b1;
      if (edges == 2) check("lockdrop_ready_e2", 32'(ready), 1);
      if (edges == 3) begin
        check("lockdrop_ready_e3", 32'(ready), 0);
        check("lockdrop_rsync_e3", 32'(rsync), 1);
        check("lockdrop_ce_e3", 32'(ce), 0);
        check("lockdrop_cdiv_e3", 32'(cdiv), 0);
      end
    end while (!(edges > 3 && ready) && edges < 100);
    check("lockdrop_relock_edges", 32'(edges), 32'(3 + 1 + LC));
    run_check(1, 2, 6, "lockdrop_after");
    $display("seq lockdrop: relock after %0d edges, checks=%0d", edges, checks);

    // Asynchronous reset mid-RUN, then default ratios without any load.
    bring_up(1, 1, 1'b1, "async");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_ready", 32'(ready), 0);
    check("async_rsync", 32'(rsync), 1);
    check("async_ce", 32'(ce), 0);
    check("async_cdiv", 32'(cdiv), 0);
    bring_up(0, 0, 1'b0, "dflt");
    run_check(6, 6, 14, "dflt");
    $display("seq async reset + default ratio, checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
